lc3_mem_ctrl: RTL
=================

// Module: lc3_mem_ctrl
// PURPOSE
//  Memory/IO access controller between MAR/MDR and main memory plus the keyboard/display.
//  - Decodes the MAR address. Runs a multi-cycle memory access. Owns the KBSR/KBDR/DSR/DDR device registers.
//  - Returns read data on MIOMUX_OUT, which feeds the MDR input, and signals completion on R.
//  - Replaces the ad-hoc wait-based status logic with a synthesizable handshake FSM.
// PARAMETERS
//  MEM_LATENCY  2        cycles from MEM_EN (read) to MEM_RDATA valid; legal range 1..7
//  DEV_BASE     16'hFE00 base of the device page; KBSR=+0, KBDR=+2, DSR=+4, DDR=+6
// PORTS
//  i_Clk        in   1   clock
//  i_Rst        in   1   synchronous reset, active-high
//  MIO_EN       in   1   access request from control; held high until R seen
//  R_W          in   1   0=read, 1=write; sampled with MIO_EN in IDLE
//  MAR_OUT      in   16  access address
//  MDR_OUT      in   16  write data
//  MIOMUX_OUT   out  16  read data to MDR, registered
//  R            out  1   access complete, one-cycle pulse
//  MEM_EN       out  1   memory strobe, one-cycle pulse
//  MEM_WE       out  1   memory write enable, coincident with MEM_EN
//  MEM_ADDR     out  16  memory address, registered at request
//  MEM_WDATA    out  16  memory write data
//  MEM_RDATA    in   16  memory read data
//  KBD_DATA     in   8   keyboard character
//  KBD_VALID    in   1   keyboard char offered
//  KBD_READY    out  1   = ~KBSR[15]; the char is accepted when KBD_VALID & KBD_READY
//  DISP_DATA    out  8   display character (DDR[7:0])
//  DISP_VALID   out  1   char offered to display
//  DISP_READY   in   1   display accepts when DISP_VALID & DISP_READY
// BEHAVIOUR
//  Reset values:
//   - MIOMUX_OUT=0, R=0, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0.
//   - KBSR=0, KBDR=0, DDR=0, DISP_VALID=0, DSR=16'h8000 (display ready).
//   - FSM=IDLE.
//  FSM states: IDLE, MEM_WAIT, DONE.
//   IDLE:
//    - On MIO_EN: latch address, data and R_W.
//    - Device hit (MAR_OUT[15:3]==DEV_BASE[15:3], MAR_OUT[0]==0): perform the register access this cycle, then go to DONE.
//    - Otherwise: pulse MEM_EN (and MEM_WE if writing).
//      - Write -> DONE.
//      - Read  -> MEM_WAIT, load the counter with MEM_LATENCY-1.
//   MEM_WAIT:
//    - Decrement the counter.
//    - At 0: capture MEM_RDATA into MIOMUX_OUT, then go to DONE.
//   DONE:
//    - R=1 for exactly one cycle, then IDLE.
//    - A new request is not accepted until the cycle after DONE, even if MIO_EN stays high.
//  Latency from the cycle MIO_EN is sampled to R high:
//   - Device access: 1 cycle.
//   - Memory write: 1 cycle.
//   - Memory read: MEM_LATENCY+1 cycles.
//  Device reads (MIOMUX_OUT):
//   - KBSR -> {KBSR[15],KBSR[14],14'b0}.
//   - KBDR -> {8'b0,KBDR[7:0]}, and clears KBSR[15].
//   - DSR  -> {DSR[15],15'b0}.
//   - DDR  -> 0.
//   - Odd device-page offsets and +8..+E are treated as memory.
//  Device writes:
//   - KBSR: only bit 14 (IE) is written.
//   - KBDR, DSR: ignored, R still pulses.
//   - DDR: load DDR[7:0], set DISP_VALID=1, clear DSR[15].
//  Keyboard:
//   - On KBD_VALID & KBD_READY, KBDR[7:0] <= KBD_DATA and KBSR[15] <= 1.
//   - A KBDR read in the same cycle as a valid char cannot occur, because KBD_READY=0 while KBSR[15]=1.
//   - A new char is accepted no earlier than the cycle after the KBDR read.
//  Display:
//   - On DISP_VALID & DISP_READY: DISP_VALID <= 0, DSR[15] <= 1.
//   - A DDR write while DSR[15]=0 overwrites DDR and keeps DISP_VALID=1 (software error; no overrun flag).
//  Reset mid-access:
//   - Abandons the access: no R pulse, MEM_EN drops, FSM goes to IDLE.
//   - All device registers go to their reset values; a pending display char is dropped.
// STRUCTURE
//  Package lc3_mmio_pkg:
//   - KBSR/KBDR/DSR/DDR offset localparams.
//   - KBSR_RDY=15, KBSR_IE=14, DSR_RDY=15 bit indices.
//   - FSM state encoding (2-bit).
//  Sub-module lc3_dev_regs:
//   - The four device registers and the KBD/DISP handshakes.
//   - Driven by decoded rd/wr strobes from the FSM.
//  The FSM, wait counter and memory port stay in lc3_mem_ctrl.
// TESTING
//  1. MEM_LATENCY=2: read 16'h3000 with memory returning 16'hBEEF.
//     - Expect MEM_EN pulse at t+0.
//     - Expect R at t+3 with MIOMUX_OUT=16'hBEEF.
//  2. Write 16'h1234 to 16'h4000.
//     - Expect MEM_EN=MEM_WE=1 and MEM_WDATA=16'h1234 at t+0.
//     - Expect R at t+1.
//     - Hold MIO_EN high: expect no second MEM_EN until t+2.
//  3. Drive KBD_DATA=8'h41 with KBD_VALID.
//     - Expect KBD_READY to drop.
//     - Read 16'hFE00: expect 16'h8000.
//     - Read 16'hFE02: expect 16'h0041 and KBD_READY high next cycle.
//  4. Write 16'h0058 to 16'hFE06 with DISP_READY=0 for 5 cycles.
//     - Expect DISP_VALID=1 and DISP_DATA=8'h58; a DSR read returns 0.
//     - Raise DISP_READY: expect DISP_VALID to drop and a DSR read to return 16'h8000.
//  5. Assert i_Rst in MEM_WAIT of a read.
//     - Expect no R pulse, FSM in IDLE, DSR=16'h8000, KBSR=0.
//     - Expect the next read to complete normally.
//  6. Write 16'hFFFF to KBSR.
//     - A KBSR read returns 16'h4000; KBD_READY stays 1.

Source files
------------

// File: rtl/lc3_mmio_pkg.sv
// Shared constants for the LC-3 memory/IO controller: device page offsets,
// status bit positions and the access FSM encoding.
package lc3_mmio_pkg;

    // Byte offsets of the device registers within the device page
    localparam logic [2:0] KBSR_OFS = 3'd0;
    localparam logic [2:0] KBDR_OFS = 3'd2;
    localparam logic [2:0] DSR_OFS  = 3'd4;
    localparam logic [2:0] DDR_OFS  = 3'd6;

    // Status register bit positions
    localparam int KBSR_RDY = 15;
    localparam int KBSR_IE  = 14;
    localparam int DSR_RDY  = 15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DONE     = 2'd2
    } mio_state_t;

    // Even offsets +0..+6 of the device page are registers; everything else is memory
    function automatic logic is_dev_hit(input logic [15:0] addr, input logic [15:0] base);
        return (addr[15:3] == base[15:3]) && !addr[0];
    endfunction

endpackage

// File: rtl/lc3_dev_regs.sv
// Keyboard and display device registers (KBSR/KBDR/DSR/DDR) together with
// the valid/ready handshakes toward the keyboard source and display sink.
module lc3_dev_regs
    import lc3_mmio_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic        wr_ie,
    input  logic [7:0]  wr_char,
    output logic [15:0] rd_data,
    input  logic [7:0]  KBD_DATA,
    input  logic        KBD_VALID,
    output logic        KBD_READY,
    output logic [7:0]  DISP_DATA,
    output logic        DISP_VALID,
    input  logic        DISP_READY
);

    localparam logic [1:0] SEL_KBSR = KBSR_OFS[2:1];
    localparam logic [1:0] SEL_KBDR = KBDR_OFS[2:1];
    localparam logic [1:0] SEL_DSR  = DSR_OFS[2:1];

    logic       kb_rdy;
    logic       kb_ie;
    logic       ds_rdy;
    logic [7:0] kbdr;
    logic [7:0] ddr;

    assign KBD_READY = ~kb_rdy;
    assign DISP_DATA = ddr;

    // Read mux; DDR and anything unmapped read as zero
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            SEL_KBSR: begin
                rd_data[KBSR_RDY] = kb_rdy;
                rd_data[KBSR_IE]  = kb_ie;
            end
            SEL_KBDR: rd_data = {8'b0, kbdr};
            SEL_DSR:  rd_data[DSR_RDY] = ds_rdy;
            default:  rd_data = '0;
        endcase
    end

    // Register updates from CPU strobes and device handshakes; a DDR write
    // takes priority over a display accept landing in the same cycle
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            kb_rdy     <= 1'b0;
            kb_ie      <= 1'b0;
            kbdr       <= '0;
            ds_rdy     <= 1'b1;
            ddr        <= '0;
            DISP_VALID <= 1'b0;
        end else begin
            if (KBD_VALID && !kb_rdy) begin
                kbdr   <= KBD_DATA;
                kb_rdy <= 1'b1;
            end else if (rd_en && reg_sel == SEL_KBDR) begin
                kb_rdy <= 1'b0;
            end

            if (wr_en && reg_sel == SEL_KBSR) begin
                kb_ie <= wr_ie;
            end

            if (wr_en && reg_sel == DDR_OFS[2:1]) begin
                ddr        <= wr_char;
                DISP_VALID <= 1'b1;
                ds_rdy     <= 1'b0;
            end else if (DISP_VALID && DISP_READY) begin
                DISP_VALID <= 1'b0;
                ds_rdy     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO access controller: decodes MAR, runs the memory handshake
// and routes device-page accesses to lc3_dev_regs.
//
//  state       | meaning
//  ------------+----------------------------------------------------------
//  ST_IDLE     | waiting for MIO_EN; device access or memory strobe issued here
//  ST_MEM_WAIT | memory read in flight, wait_cnt counts down to data valid
//  ST_DONE     | access finished; R pulses on leaving this state
module lc3_mem_ctrl
    import lc3_mmio_pkg::*;
#(
    parameter int          MEM_LATENCY = 2,
    parameter logic [15:0] DEV_BASE    = 16'hFE00
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR_OUT,
    input  logic [15:0] MDR_OUT,
    output logic [15:0] MIOMUX_OUT,
    output logic        R,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    input  logic [15:0] MEM_RDATA,
    input  logic [7:0]  KBD_DATA,
    input  logic        KBD_VALID,
    output logic        KBD_READY,
    output logic [7:0]  DISP_DATA,
    output logic        DISP_VALID,
    input  logic        DISP_READY
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

    mio_state_t  state;
    logic [2:0]  wait_cnt;
    logic        dev_hit;
    logic        dev_rd;
    logic        dev_wr;
    logic [15:0] dev_rdata;

    // Device strobes are only raised in the single IDLE cycle that accepts a request
    assign dev_hit = is_dev_hit(MAR_OUT, DEV_BASE);
    assign dev_rd  = (state == ST_IDLE) && MIO_EN && dev_hit && !R_W;
    assign dev_wr  = (state == ST_IDLE) && MIO_EN && dev_hit && R_W;

    lc3_dev_regs u_dev_regs (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .rd_en      (dev_rd),
        .wr_en      (dev_wr),
        .reg_sel    (MAR_OUT[2:1]),
        .wr_ie      (MDR_OUT[KBSR_IE]),
        .wr_char    (MDR_OUT[7:0]),
        .rd_data    (dev_rdata),
        .KBD_DATA   (KBD_DATA),
        .KBD_VALID  (KBD_VALID),
        .KBD_READY  (KBD_READY),
        .DISP_DATA  (DISP_DATA),
        .DISP_VALID (DISP_VALID),
        .DISP_READY (DISP_READY)
    );

    // Access FSM with registered memory-port and completion outputs
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            MIOMUX_OUT <= '0;
            R          <= 1'b0;
            MEM_EN     <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
        end else begin
            R      <= 1'b0;
            MEM_EN <= 1'b0;
            MEM_WE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (MIO_EN) begin
                        MEM_ADDR  <= MAR_OUT;
                        MEM_WDATA <= MDR_OUT;
                        if (dev_hit) begin
                            if (!R_W) begin
                                MIOMUX_OUT <= dev_rdata;
                            end
                            state <= ST_DONE;
                        end else begin
                            MEM_EN <= 1'b1;
                            MEM_WE <= R_W;
                            if (R_W) begin
                                state <= ST_DONE;
                            end else begin
                                wait_cnt <= LAT_LOAD;
                                state    <= ST_MEM_WAIT;
                            end
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (wait_cnt == '0) begin
                        MIOMUX_OUT <= MEM_RDATA;
                        state      <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    R     <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
